// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - carry-segmented pipelined adder/subtractor with valid/ready handshake
// Each stage resolves one SEG-bit slice of the carry chain; the whole pipe moves in lockstep.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    generate
        if (SEG < 1 || WIDTH < 2 || (WIDTH % SEG) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be >= 2 and a multiple of SEG >= 1");
        end
    endgenerate

    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [SEG:0]     seg_t;

    // Subtraction is folded into the adder: b is inverted up front and the
    // inverted borrow-in becomes the carry-in, so later stages never see sub.
    always_comb begin
        adv   = !v_q[LAST] || out_ready;
        b_eff = sub ? ~b : b;
        seg_t = '0;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            r_d[k] = r_q[k];
            c_d[k] = c_q[k];
        end
        if (adv) begin
            seg_t  = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]} + {{SEG{1'b0}}, cin ^ sub};
            v_d[0] = in_valid;
            a_d[0] = a;
            b_d[0] = b_eff;
            r_d[0] = '0;
            r_d[0][SEG-1:0] = seg_t[SEG-1:0];
            c_d[0] = seg_t[SEG];
            for (int k = 1; k < STAGES; k++) begin
                seg_t  = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                         + {{SEG{1'b0}}, c_q[k-1]};
                v_d[k] = v_q[k-1];
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                r_d[k] = r_q[k-1];
                r_d[k][k*SEG +: SEG] = seg_t[SEG-1:0];
                c_d[k] = seg_t[SEG];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    assign in_ready  = adv && !rst;
    assign out_valid = v_q[LAST];
    assign sum       = {c_q[LAST], r_q[LAST]};
    // Operand MSBs agree but the result MSB does not: signed overflow.
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                       && (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and randomized checks of pipelined_adder in three geometries
module tb_pipelined_adder;

    localparam int W [3] = '{16, 8, 12};

    logic        clk;
    logic        rst;
    logic [15:0] a_x [3];
    logic [15:0] b_x [3];
    logic        cin_x [3];
    logic        sub_x [3];
    logic        iv_x [3];
    logic        or_x [3];
    logic        ir_x [3];
    logic        ov_x [3];
    logic        ovf_x [3];
    logic [16:0] sum_x [3];
    logic [16:0] sum16;
    logic [8:0]  sum8;
    logic [12:0] sum12;

    int tests = 0;
    int fails = 0;
    int pops [3];
    int acc [3];
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];

    assign sum_x[0] = sum16;
    assign sum_x[1] = {8'd0, sum8};
    assign sum_x[2] = {4'd0, sum12};

    pipelined_adder #(.WIDTH(16), .SEG(4)) u16 (
        .clk(clk), .rst(rst), .a(a_x[0]), .b(b_x[0]), .cin(cin_x[0]), .sub(sub_x[0]),
        .in_valid(iv_x[0]), .in_ready(ir_x[0]), .sum(sum16), .ovf(ovf_x[0]),
        .out_valid(ov_x[0]), .out_ready(or_x[0]));

    pipelined_adder #(.WIDTH(8), .SEG(8)) u8 (
        .clk(clk), .rst(rst), .a(a_x[1][7:0]), .b(b_x[1][7:0]), .cin(cin_x[1]), .sub(sub_x[1]),
        .in_valid(iv_x[1]), .in_ready(ir_x[1]), .sum(sum8), .ovf(ovf_x[1]),
        .out_valid(ov_x[1]), .out_ready(or_x[1]));

    pipelined_adder #(.WIDTH(12), .SEG(3)) u12 (
        .clk(clk), .rst(rst), .a(a_x[2][11:0]), .b(b_x[2][11:0]), .cin(cin_x[2]), .sub(sub_x[2]),
        .in_valid(iv_x[2]), .in_ready(ir_x[2]), .sum(sum12), .ovf(ovf_x[2]),
        .out_valid(ov_x[2]), .out_ready(or_x[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] msk(int w);
        return 16'((32'd1 << w) - 32'd1);
    endfunction

    // Reference: plain signed/unsigned integer arithmetic, packed as ovf<<20 | sum.
    function automatic logic [63:0] model(int w, longint a, longint b, bit cin, bit sub);
        longint h, full, sa, sb, c, u, s;
        bit co, ov;
        h    = 64'sd1 <<< (w - 1);
        full = h * 2;
        sa   = (a >= h) ? a - full : a;
        sb   = (b >= h) ? b - full : b;
        c    = cin ? 64'sd1 : 64'sd0;
        if (!sub) begin
            u  = a + b + c;
            co = (u >= full);
            s  = sa + sb + c;
        end else begin
            u  = a - b - c;
            co = (u >= 0);
            s  = sa - sb - c;
        end
        ov = (s < -h) || (s >= h);
        return (64'(ov) << 20) | (64'(co) << w) | 64'(u & (full - 1));
    endfunction

    function automatic logic [63:0] obs(int i);
        return {43'd0, ovf_x[i], 3'd0, sum_x[i]};
    endfunction

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [63:0] qpop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(int i, logic [63:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic void qclear(int i);
        case (i)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard bookkeeping for the coming edge, then advance one clock.
    task automatic tick();
        logic [63:0] e;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                qclear(i);
            end else begin
                if (ov_x[i] && or_x[i]) begin
                    pops[i]++;
                    if (qsize(i) == 0) begin
                        chk("sb_extra_output", 64'(ov_x[i]), 64'd0);
                    end else begin
                        e = qpop(i);
                        chk("sb_result", obs(i), e);
                    end
                end
                if (iv_x[i] && ir_x[i]) begin
                    acc[i]++;
                    qpush(i, model(W[i], longint'(a_x[i] & msk(W[i])), longint'(b_x[i] & msk(W[i])),
                                   cin_x[i], sub_x[i]));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(int i, string tag, logic [15:0] a, logic [15:0] b, bit cin, bit sub,
                            logic [16:0] es, bit eo, int lat);
        int cyc;
        a_x[i] = a; b_x[i] = b; cin_x[i] = cin; sub_x[i] = sub;
        iv_x[i] = 1'b1; or_x[i] = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(ir_x[i]), 64'd1);
        tick();
        iv_x[i] = 1'b0;
        cyc = 1;
        while (!ov_x[i] && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_sum"}, 64'(sum_x[i]), 64'(es));
        chk({tag, "_ovf"}, 64'(ovf_x[i]), 64'(eo));
        tick();
    endtask

    initial begin
        int sent, base, n;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_x[i] = '0; b_x[i] = '0; cin_x[i] = 0; sub_x[i] = 0;
            iv_x[i] = 0; or_x[i] = 1; pops[i] = 0; acc[i] = 0;
        end
        @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(ir_x[0]), 64'd0);
        tick();
        chk("reset_out_valid", 64'(ov_x[0]), 64'd0);
        chk("reset_sum", 64'(sum_x[0]), 64'd0);
        chk("reset_ovf", 64'(ovf_x[0]), 64'd0);
        rst = 1'b0;

        directed(0, "add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 4);
        directed(0, "sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0, 4);
        directed(0, "sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 4);
        directed(0, "add_7fff", 16'h7FFF, 16'h0001, 1'b1, 1'b0, 17'h08001, 1'b1, 4);
        directed(1, "w8_add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0, 1);
        directed(2, "w12_sub", 16'h0000, 16'h0001, 1'b1, 1'b1, 17'h00FFE, 1'b0, 4);

        // Six back-to-back adds, consumer stalls for three cycles.
        sent = 0;
        base = pops[0];
        for (int c = 0; c < 16; c++) begin
            or_x[0] = !(c >= 5 && c <= 7);
            iv_x[0] = (sent < 6);
            a_x[0] = 16'($urandom);
            b_x[0] = 16'($urandom);
            cin_x[0] = 1'($urandom);
            sub_x[0] = 1'b0;
            #1;
            chk("stall_in_ready", 64'(ir_x[0]), 64'(!(c >= 5 && c <= 7)));
            if (c >= 5 && c <= 7) begin
                chk("stall_out_valid", 64'(ov_x[0]), 64'd1);
                chk("stall_hold", obs(0), q0[0]);
            end
            if (iv_x[0] && ir_x[0]) sent++;
            tick();
        end
        iv_x[0] = 1'b0;
        or_x[0] = 1'b1;
        chk("stall_count", 64'(pops[0] - base), 64'd6);
        chk("stall_drained", 64'(qsize(0)), 64'd0);

        // Reset with two items in flight; the offered item must not be taken.
        base = pops[0];
        for (int c = 0; c < 2; c++) begin
            iv_x[0] = 1'b1;
            a_x[0] = 16'($urandom);
            b_x[0] = 16'($urandom);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(ir_x[0]), 64'd0);
        tick();
        rst = 1'b0;
        iv_x[0] = 1'b0;
        chk("rst_out_valid", 64'(ov_x[0]), 64'd0);
        chk("rst_sum", 64'(sum_x[0]), 64'd0);
        chk("rst_ovf", 64'(ovf_x[0]), 64'd0);
        directed(0, "post_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 17'h02233, 1'b0, 4);
        for (int c = 0; c < 6; c++) tick();
        chk("rst_count", 64'(pops[0] - base), 64'd1);

        // Random traffic on all three geometries against the model.
        for (int i = 0; i < 3; i++) acc[i] = 0;
        n = 0;
        while ((acc[0] < 1000 || acc[1] < 1000 || acc[2] < 1000) && n < 6000) begin
            for (int i = 0; i < 3; i++) begin
                a_x[i]   = 16'($urandom) & msk(W[i]);
                b_x[i]   = 16'($urandom) & msk(W[i]);
                cin_x[i] = 1'($urandom);
                sub_x[i] = 1'($urandom);
                iv_x[i]  = ($urandom_range(3) != 0);
                or_x[i]  = ($urandom_range(3) != 0);
            end
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            iv_x[i] = 1'b0;
            or_x[i] = 1'b1;
        end
        for (int c = 0; c < 10; c++) tick();
        for (int i = 0; i < 3; i++) begin
            chk("rnd_accepted", 64'(acc[i] >= 1000), 64'd1);
            chk("rnd_drained", 64'(qsize(i)), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 16: operand width in bits, minimum 2.
REQ-002 The block SHALL have the parameter SEG, default 4: carry-segment width; WIDTH SHALL be an integer multiple of SEG, with STAGES = WIDTH/SEG.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have the ports a and b, input, WIDTH bits each: the operands.
REQ-006 The block SHALL have the port cin, input, 1 bit: carry-in in add mode, borrow-in in subtract mode.
REQ-007 The block SHALL have the port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-008 The block SHALL have the ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-009 The block SHALL have the port sum, output, WIDTH+1 bits: the result, with sum[WIDTH] = carry-out.
REQ-010 The block SHALL have the port ovf, output, 1 bit: two's-complement signed overflow of the result.
REQ-011 The block SHALL have the ports out_valid (output, 1) and out_ready (input, 1): the output handshake.

Function
REQ-012 Add mode SHALL compute sum = a + b + cin.
REQ-013 Subtract mode SHALL compute a + ~b + ~cin, so that a - b - cin appears in sum[WIDTH-1:0]; sum[WIDTH] = 1 means no borrow.
REQ-014 ovf SHALL be 1 iff the effective operands a and (sub ? ~b : b) have equal MSBs and sum[WIDTH-1] differs from them.
REQ-015 The carry chain SHALL be split into STAGES registered segments; stage k adds bits [k*SEG+SEG-1 : k*SEG] using the registered carry from stage k-1.
REQ-016 Stage k SHALL delay the not-yet-added operand bits and the completed low result bits alongside the carry.
REQ-017 Each stage SHALL hold a valid bit.
REQ-018 The pipeline SHALL advance globally when adv = !out_valid || out_ready; on an advance every stage loads from the stage before it, and stage 1 loads the inputs with valid = in_valid.
REQ-019 in_ready SHALL equal adv && !rst; a transfer is accepted on a rising edge where in_valid && in_ready.
REQ-020 Latency SHALL be STAGES cycles: with no stall, an item accepted at edge N drives out_valid = 1 after edge N+STAGES-1, i.e. out_valid is high in the STAGES-th cycle after acceptance.
REQ-021 Throughput SHALL be one item per cycle.
REQ-022 Bubbles are not squeezed out: an empty stage advances like a full one.
REQ-023 While out_valid = 1 and out_ready = 0, the pipeline SHALL freeze; sum, ovf and out_valid stay stable and no stage changes.
REQ-024 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-025 When in_valid = 0 on an advance, a bubble (valid = 0) SHALL enter stage 1, and the operand registers MAY take any value.
REQ-026 Simultaneous output consume and input accept in the same cycle SHALL both take effect.
REQ-027 With STAGES = 1, the block SHALL degenerate to a single registered adder with latency 1 and the same handshake.
REQ-028 Parameter legality (WIDTH mod SEG = 0, SEG >= 1) SHALL be checked at elaboration; an illegal combination fails elaboration.

Reset
REQ-029 On a rising edge with rst = 1, all stage valid bits SHALL clear, out_valid SHALL be 0, and sum and ovf SHALL be 0.
REQ-030 In-flight items SHALL be discarded and SHALL never appear at the output.
REQ-031 rst SHALL dominate the handshake: in_ready = 0 in any cycle with rst = 1, and no item is accepted on that edge.
REQ-032 The first accept after reset SHALL be possible in the first cycle with rst = 0.

Verification (WIDTH=16, SEG=4, STAGES=4 unless noted)
REQ-033 The bench SHALL apply add a=0xFFFF, b=0x0001, cin=0 -> sum=0x10000, ovf=0, out_valid in the 4th cycle after accept.
REQ-034 The bench SHALL apply sub a=0x0005, b=0x0007, cin=0 -> sum=0x0FFFE (MSB 0 = borrow), ovf=0; and sub a=0x8000, b=0x0001 -> sum=0x17FFF, ovf=1.
REQ-035 The bench SHALL apply add a=0x7FFF, b=0x0001, cin=1 -> sum=0x08001, ovf=1.
REQ-036 The bench SHALL stream 6 back-to-back adds with out_ready held low 3 cycles mid-stream -> in_ready low exactly while the stall holds, outputs frozen, all 6 results in order, none lost or repeated.
REQ-037 The bench SHALL assert rst for 1 cycle with 2 items in flight -> out_valid=0 and sum=0 the next cycle, those 2 results never emitted, and a new item accepted immediately after completes normally.
REQ-038 The bench SHALL compare 1000 random add/sub vectors with random in_valid/out_ready against a behavioural model for (WIDTH,SEG) = (16,4), (8,8) and (12,3) -> zero mismatches.
